uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter. It is the successor to the fixed 8N1, pushbutton-driven transmitter.
- Runs entirely on CLOCK_50 with a baud-tick enable; no derived clock.
- Configurable data width, parity and stop bits.
- Takes words over a valid/ready handshake into a one-entry holding buffer, so back-to-back frames go out with zero idle gap.
- Sits between any byte producer (test pattern, FIFO, CPU register) and the UART_TX pin.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Bit period DIV = (CLK_FREQ + BAUD/2) / BAUD clocks, integer rounded (434 at the defaults). DIV < 2 is illegal and must be flagged at elaboration.
- DATA_BITS, 8, payload bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  word to send. The LSB goes on the line first.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  holding buffer empty. A word is accepted on any edge where tx_valid & tx_ready.
- UART_TX  out  1  serial line, registered, idles high.
- tx_busy  out  1  high while a frame (start through last stop bit) is on the line.
- frame_count  out  16  number of completed frames, wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async assert, sync-safe release):
  - UART_TX = 1, tx_busy = 0, frame_count = 0.
  - Holding buffer empty; state = IDLE; bit timer = 0.
  - tx_ready = 0 while reset is high, and 1 on the first cycle after release.
- Reset mid-frame: the line returns high immediately and the word in flight plus the buffered word are discarded. No partial stop bit is emitted.
- Handshake:
  - tx_ready = ~hold_full.
  - On accept, tx_data is captured into the hold register and hold_full is set.
  - tx_data and tx_valid are ignored when tx_ready = 0.
  - The producer may hold tx_valid high continuously.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE or START.
  - PARITY is skipped when PARITY = 0.
  - STOP lasts STOP_BITS bit periods.
- Load: the shifter loads from hold when hold_full is set and the state is IDLE, or at the final clock of the last stop bit.
  - On load, hold_full clears, so tx_ready rises the next cycle.
  - A word accepted at edge N while IDLE gives UART_TX = 0 after edge N+1 (1 cycle latency).
- Bit timing:
  - Each line bit is driven for exactly DIV clocks.
  - The timer reloads to DIV-1 on entering each bit and counts down. The bit advances when the timer is 0.
  - Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV clocks.
- DATA: bit i of the word is driven during the i-th data bit period, i = 0..DATA_BITS-1.
- Parity bit value:
  - Odd: ~^data, so the ones count over data+parity is odd.
  - Even: ^data.
- Back-to-back: if hold_full is set at the last clock of the final stop bit, START begins on the next clock with no idle cycle. tx_busy stays high across the boundary.
- frame_count increments by 1 on the last clock of each final stop bit.
- tx_busy = 1 from the first START clock through the last STOP clock; otherwise 0.
- Hold timing: a word accepted during a frame waits in hold, and tx_ready stays low until it is loaded.
- Same-edge load and accept: when load and a new accept would coincide, no accept occurs because tx_ready was 0 that cycle. The producer's word is accepted on the following cycle.

Test Plan:
All scenarios use bench parameters CLK_FREQ = 1000000 and BAUD = 100000, giving DIV = 10.
1. 8N1, send 0x55 once.
   - UART_TX low at accept+1 for 10 clocks.
   - Then data bits 1,0,1,0,1,0,1,0 at 10 clocks each, then high for 10 clocks.
   - tx_busy high for 100 clocks; frame_count = 1.
2. 8O1 with 0x07, then 8E1 with 0x07.
   - Parity bit 0 (odd) and 1 (even) respectively.
   - Frame = 110 clocks.
3. 7N2, three words with tx_valid held high: 0x41, 0x42, 0x43.
   - Three 100-clock frames with no idle cycle between them.
   - tx_ready low except for one cycle after each load.
   - frame_count = 3.
4. tx_valid pulsed while tx_ready = 0 mid-frame.
   - Word ignored; next frame carries only the previously held word.
5. reset asserted at clock 37 of a 0xA5 frame.
   - UART_TX = 1 and tx_busy = 0 asynchronously; frame_count = 0.
   - tx_ready = 1 one cycle after release; the next word transmits cleanly.
6. Preload frame_count to 0xFFFF by sending 65535 frames (or force).
   - One more frame -> frame_count = 0x0000.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding buffer.
// Configurable data width, parity and stop bits; baud-tick timing on CLOCK_50.
module uart_tx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 UART_TX,
  output logic                 tx_busy,
  output logic [15:0]          frame_count
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0] TOP    = TW'(DIV - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [3:0]    LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: bit period DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic                 line_q;
  logic                 busy_q;
  logic [15:0]          fc_q;

  logic tick;
  logic last_stop;
  logic load;
  logic accept;
  logic par_calc;

  // Handshake, bit-timer and load decisions.
  always_comb begin
    tx_ready  = ~hold_full & ~reset;
    accept    = tx_valid & tx_ready;
    tick      = (timer == '0);
    last_stop = (state == S_STOP) && tick && (bit_cnt == LAST_S);
    load      = hold_full && ((state == S_IDLE) || last_stop);
    par_calc  = (PARITY == 1) ? ~^hold : ^hold;
  end

  // Holding buffer: filled on accept, emptied when the shifter loads.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end
  end

  // Frame sequencer: each line bit lasts DIV clocks, line is registered.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else if (load) begin
      state   <= S_START;
      timer   <= TOP;
      bit_cnt <= '0;
      shreg   <= hold;
      par_q   <= par_calc;
      line_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else if (state != S_IDLE && !tick) begin
      timer <= timer - T_ONE;
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_START: begin
          state  <= S_DATA;
          timer  <= TOP;
          line_q <= shreg[0];
        end
        S_DATA: begin
          timer <= TOP;
          if (bit_cnt == LAST_D) begin
            bit_cnt <= '0;
            if (PARITY != 0) begin
              state  <= S_PAR;
              line_q <= par_q;
            end else begin
              state  <= S_STOP;
              line_q <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            shreg   <= shreg >> 1;
            line_q  <= shreg[1];
          end
        end
        S_PAR: begin
          state   <= S_STOP;
          timer   <= TOP;
          bit_cnt <= '0;
          line_q  <= 1'b1;
        end
        S_STOP: begin
          if (bit_cnt == LAST_S) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            line_q <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            timer   <= TOP;
          end
        end
        default: begin
          state  <= S_IDLE;
          line_q <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Completed-frame counter, bumped on the last clock of the final stop bit.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      fc_q <= '0;
    end else if (last_stop) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign UART_TX     = line_q;
  assign tx_busy     = busy_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations checked cycle by cycle
// against a frame-level waveform model.
module tb_uart_tx_param;

  localparam int CF  = 1000000;
  localparam int BD  = 100000;
  localparam int DIV = (CF + BD / 2) / BD;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_b;
  logic [3:0]  valid;
  logic [3:0]  rdy;
  logic [3:0]  line;
  logic [3:0]  busy;
  logic [15:0] fc [4];

  int dbits [4] = '{8, 8, 8, 7};
  int par   [4] = '{0, 1, 2, 0};
  int stp   [4] = '{1, 1, 1, 2};

  logic [15:0] fc_exp [4];
  logic [7:0]  wq [$];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) u0 (
    .CLOCK_50(clk), .reset(rst), .tx_data(data_b),
    .tx_valid(valid[0]), .tx_ready(rdy[0]), .UART_TX(line[0]),
    .tx_busy(busy[0]), .frame_count(fc[0]));

  uart_tx_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1)) u1 (
    .CLOCK_50(clk), .reset(rst), .tx_data(data_b),
    .tx_valid(valid[1]), .tx_ready(rdy[1]), .UART_TX(line[1]),
    .tx_busy(busy[1]), .frame_count(fc[1]));

  uart_tx_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1)) u2 (
    .CLOCK_50(clk), .reset(rst), .tx_data(data_b),
    .tx_valid(valid[2]), .tx_ready(rdy[2]), .UART_TX(line[2]),
    .tx_busy(busy[2]), .frame_count(fc[2]));

  uart_tx_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(7),
                  .PARITY(0), .STOP_BITS(2)) u3 (
    .CLOCK_50(clk), .reset(rst), .tx_data(data_b[6:0]),
    .tx_valid(valid[3]), .tx_ready(rdy[3]), .UART_TX(line[3]),
    .tx_busy(busy[3]), .frame_count(fc[3]));

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Line level of bit slot b of a frame carrying word w.
  function automatic logic fbit(input int s, input logic [7:0] w,
                                input int b);
    int d;
    int ones;
    logic [7:0] m;
    d = dbits[s];
    m = w & 8'((1 << d) - 1);
    ones = $countones(m);
    if (b == 0) return 1'b0;
    if (b <= d) return m[b-1];
    if (par[s] != 0 && b == d + 1)
      return (par[s] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    return 1'b1;
  endfunction

  // Sends wq on instance s with tx_valid held; checks every cycle.
  task automatic run(input int s, input bit glitch);
    int n, d, fl, wi, gc, last, a;
    bit acc;
    logic exp_rdy, exp_busy, exp_line;
    logic [15:0] fb, efc;
    n    = wq.size();
    d    = dbits[s];
    fl   = (1 + d + ((par[s] != 0) ? 1 : 0) + stp[s]) * DIV;
    wi   = 0;
    gc   = 2 + fl / 2;
    last = 2 + n * fl + 3;
    fb   = fc_exp[s];
    @(negedge clk);
    chk($sformatf("s%0d ready_idle", s), 16'(rdy[s]), 16'd1);
    data_b   = wq[0];
    valid[s] = 1'b1;
    for (int c = 1; c <= last; c++) begin
      acc = valid[s] & rdy[s];
      @(posedge clk);
      @(negedge clk);
      if (acc && wi < n) wi++;
      exp_busy = (c >= 2) && (c <= 1 + n * fl);
      exp_line = 1'b1;
      if (exp_busy)
        exp_line = fbit(s, wq[(c-2)/fl], ((c-2) % fl) / DIV);
      exp_rdy = 1'b1;
      efc = fb;
      for (int j = 0; j < n; j++) begin
        a = (j == 0) ? 1 : 3 + (j - 1) * fl;
        if (c >= a && c < 2 + j * fl) exp_rdy = 1'b0;
        if (2 + (j + 1) * fl <= c) efc = efc + 16'd1;
      end
      chk($sformatf("s%0d c%0d line", s, c), 16'(line[s]), 16'(exp_line));
      chk($sformatf("s%0d c%0d busy", s, c), 16'(busy[s]), 16'(exp_busy));
      chk($sformatf("s%0d c%0d ready", s, c), 16'(rdy[s]), 16'(exp_rdy));
      chk($sformatf("s%0d c%0d count", s, c), fc[s], efc);
      if (wi < n) begin
        valid[s] = 1'b1;
        data_b   = wq[wi];
      end else if (glitch && c == gc && !rdy[s]) begin
        valid[s] = 1'b1;
        data_b   = ~wq[n-1];
      end else begin
        valid[s] = 1'b0;
      end
    end
    valid[s]  = 1'b0;
    fc_exp[s] = fb + 16'(n);
  endtask

  initial begin
    rst    = 1'b1;
    valid  = '0;
    data_b = '0;
    for (int i = 0; i < 4; i++) fc_exp[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst%0d line", i), 16'(line[i]), 16'd1);
      chk($sformatf("rst%0d busy", i), 16'(busy[i]), 16'd0);
      chk($sformatf("rst%0d ready", i), 16'(rdy[i]), 16'd0);
      chk($sformatf("rst%0d count", i), fc[i], 16'd0);
    end
    #1 rst = 1'b0;
    #1 chk("rel ready", 16'(rdy[0]), 16'd1);

    wq = {}; wq.push_back(8'h55);
    run(0, 1'b0);

    wq = {}; wq.push_back(8'h07);
    run(1, 1'b0);
    wq = {}; wq.push_back(8'h07);
    run(2, 1'b0);

    wq = {}; wq.push_back(8'h41); wq.push_back(8'h42); wq.push_back(8'h43);
    run(3, 1'b0);

    wq = {}; wq.push_back(8'h3C); wq.push_back(8'hC9);
    run(0, 1'b1);

    for (int s = 0; s < 4; s++) begin
      wq = {};
      for (int k = 0; k < 3; k++) wq.push_back(8'($urandom_range(0, 255)));
      run(s, 1'b0);
    end

    @(negedge clk);
    data_b   = 8'hA5;
    valid[0] = 1'b1;
    chk("mid ready0", 16'(rdy[0]), 16'd1);
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    chk("mid held", 16'(rdy[0]), 16'd0);
    repeat (37) @(posedge clk);
    #2;
    chk("mid busy", 16'(busy[0]), 16'd1);
    chk("mid line", 16'(line[0]), 16'(fbit(0, 8'hA5, 3)));
    rst = 1'b1;
    #1;
    chk("arst line", 16'(line[0]), 16'd1);
    chk("arst busy", 16'(busy[0]), 16'd0);
    chk("arst ready", 16'(rdy[0]), 16'd0);
    chk("arst count", fc[0], 16'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rel2 ready", 16'(rdy[0]), 16'd1);
    chk("rel2 line", 16'(line[0]), 16'd1);
    for (int i = 0; i < 4; i++) fc_exp[i] = '0;
    wq = {}; wq.push_back(8'($urandom_range(0, 255)));
    run(0, 1'b0);

    @(negedge clk);
    force u0.fc_q = 16'hFFFF;
    #1 release u0.fc_q;
    #1 chk("preload", fc[0], 16'hFFFF);
    fc_exp[0] = 16'hFFFF;
    wq = {}; wq.push_back(8'($urandom_range(0, 255)));
    run(0, 1'b0);
    chk("wrap", fc[0], 16'h0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
